// File: rtl/simon_pkg.sv
// Shared types and constants for the Simon Says color datapath.
// Includes the Galois LFSR step used by the sequence generator.
package simon_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    DONE
  } stateT;

  localparam int NUM_COLORS = 16;
  localparam int COLOR_W    = 2;

  localparam logic [15:0] LFSR_MASK = 16'hB400;

  localparam logic [COLOR_W-1:0] RED    = 2'd0;
  localparam logic [COLOR_W-1:0] GREEN  = 2'd1;
  localparam logic [COLOR_W-1:0] BLUE   = 2'd2;
  localparam logic [COLOR_W-1:0] YELLOW = 2'd3;

  // Right-shifting Galois form: the bit shifted out decides whether the taps are applied.
  function automatic logic [15:0] lfsrStep(input logic [15:0] cur);
    lfsrStep = cur[0] ? ((cur >> 1) ^ LFSR_MASK) : (cur >> 1);
  endfunction

endpackage

// File: rtl/color_sequence_gen_if.sv
// Bus between the color sequence generator and the color master.
// The generator uses the slave view; the color master uses the master view.
interface color_sequence_gen_if;

  logic        SetColors;
  logic [31:0] Colors;
  logic        ColorsValid;
  logic        Busy;
  logic        IncCounter;

  modport master (
    output SetColors,
    input  Colors,
    input  ColorsValid,
    input  Busy,
    input  IncCounter
  );

  modport slave (
    input  SetColors,
    output Colors,
    output ColorsValid,
    output Busy,
    output IncCounter
  );

endinterface

// File: rtl/lfsr16.sv
// Free-running 16-bit Galois LFSR; steps every cycle out of reset.
// A zero seed would lock the register at zero, so it is replaced by 1.
module lfsr16
  import simon_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] q
);

  localparam logic [15:0] EFF_SEED = (SEED == 16'h0000) ? 16'h0001 : SEED;

  always_ff @(posedge clk) begin
    if (!reset) begin
      q <= EFF_SEED;
    end else begin
      q <= lfsrStep(q);
    end
  end

endmodule

// File: rtl/color_sequence_gen.sv
// Builds a 16-entry pseudo-random color sequence on each SetColors rising edge
// and produces the periodic playback strobe IncCounter.
module color_sequence_gen
  import simon_pkg::*;
#(
  parameter int unsigned  TICK_DIV  = 50_000_000,
  parameter logic [15:0]  LFSR_SEED = 16'hACE1
) (
  input  logic                clk,
  input  logic                reset,
  color_sequence_gen_if.slave bus
);

  localparam int unsigned      PCNT_W   = $clog2(TICK_DIV);
  localparam logic [PCNT_W-1:0] TICK_MAX = PCNT_W'(TICK_DIV - 1);
  localparam logic [3:0]        LAST_IDX = 4'(NUM_COLORS - 1);

  logic [15:0]       lfsrQ;
  logic              unusedLfsrHi;
  logic              setQ;
  logic              reqEdge;
  stateT             state;
  stateT             nextState;
  logic [3:0]        idx;
  logic [3:0]        idxNext;
  logic [31:0]       shadow;
  logic [31:0]       shadowNext;
  logic              doneEntry;
  logic              fillStart;
  logic [PCNT_W-1:0] pcnt;
  logic [PCNT_W-1:0] pcntNext;
  logic [31:0]       colorsQ;
  logic              validQ;
  logic              busyQ;
  logic              incQ;

  lfsr16 #(
    .SEED (LFSR_SEED)
  ) uLfsr (
    .clk   (clk),
    .reset (reset),
    .q     (lfsrQ)
  );

  assign unusedLfsrHi = ^lfsrQ[15:COLOR_W];

  assign reqEdge = bus.SetColors & ~setQ;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // One draw per FILL cycle; edges that arrive mid-fill fall through unhandled.
  always_comb begin
    nextState  = state;
    idxNext    = idx;
    shadowNext = shadow;
    case (state)
      IDLE, DONE: begin
        if (reqEdge) begin
          nextState = FILL;
          idxNext   = 4'd0;
        end
      end
      FILL: begin
        shadowNext[{idx, 1'b0} +: COLOR_W] = lfsrQ[COLOR_W-1:0];
        idxNext = idx + 4'd1;
        if (idx == LAST_IDX) begin
          nextState = DONE;
        end
      end
      default: nextState = IDLE;
    endcase
  end

  assign doneEntry = (state == FILL) && (nextState == DONE);
  assign fillStart = (state != FILL) && (nextState == FILL);

  // The last draw lands in shadowNext, so that is what gets published.
  always_comb begin
    pcntNext = pcnt + 1'b1;
    if (doneEntry || (pcnt == TICK_MAX)) begin
      pcntNext = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      setQ    <= 1'b0;
      idx     <= 4'd0;
      shadow  <= 32'd0;
      pcnt    <= '0;
      colorsQ <= 32'd0;
      validQ  <= 1'b0;
      busyQ   <= 1'b0;
      incQ    <= 1'b0;
    end else begin
      setQ   <= bus.SetColors;
      idx    <= idxNext;
      shadow <= shadowNext;
      pcnt   <= pcntNext;
      busyQ  <= (nextState == FILL);
      incQ   <= (pcntNext == TICK_MAX);
      if (doneEntry) begin
        colorsQ <= shadowNext;
        validQ  <= 1'b1;
      end else if (fillStart) begin
        validQ  <= 1'b0;
      end
    end
  end

  assign bus.Colors      = colorsQ;
  assign bus.ColorsValid = validQ;
  assign bus.Busy        = busyQ;
  assign bus.IncCounter  = incQ;

endmodule

// File: tb/tb_color_sequence_gen.sv
// Directed bench for color_sequence_gen: per-cycle vector table with its own
// LFSR reference, then hand sequences for latency and strobe spacing.
module tb_color_sequence_gen;
  import simon_pkg::*;

  localparam int          TICKS = 4;
  localparam logic [15:0] SEED  = 16'hACE1;
  localparam int          NCYC  = 80;

  logic clk = 1'b0;
  logic reset;
  logic curReset;

  color_sequence_gen_if bus();

  color_sequence_gen #(
    .TICK_DIV  (TICKS),
    .LFSR_SEED (SEED)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       set;
    logic       expBusy;
    logic       expValid;
    logic       expInc;
    logic [1:0] colorsSel;
  } vecT;

  vecT         vecs [NCYC];
  int          testsRun    = 0;
  int          testsFailed = 0;
  logic [15:0] modelLfsr;
  logic [31:0] seqs [4];
  logic [31:0] seqD;
  int          incCycles [18] = '{3, 7, 11, 15, 19, 25, 29, 33, 37, 41, 46, 50, 54, 61, 65, 69, 73, 78};

  function automatic logic [15:0] refStep(input logic [15:0] v);
    refStep = v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic s);
    reset         = r;
    bus.SetColors = s;
    curReset      = r;
  endtask

  // Moves the reference LFSR and the DUT to the next cycle together.
  task automatic advance();
    modelLfsr = curReset ? refStep(modelLfsr) : SEED;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int lat;
    int n;
    logic found;

    for (int i = 0; i < NCYC; i++) begin
      vecs[i] = '{rst: 1'b1, set: 1'b0, expBusy: 1'b0, expValid: 1'b0, expInc: 1'b0, colorsSel: 2'd0};
      if ((i >= 5 && i <= 8) || (i >= 10 && i <= 23) || (i >= 26 && i <= 47) || (i >= 49)) vecs[i].set = 1'b1;
      if (i == 57) vecs[i].rst = 1'b0;
      if ((i >= 6 && i <= 21) || (i >= 27 && i <= 42) || (i >= 50 && i <= 57) || (i >= 59 && i <= 74)) vecs[i].expBusy = 1'b1;
      if ((i >= 22 && i <= 26) || (i >= 43 && i <= 49) || (i >= 75)) vecs[i].expValid = 1'b1;
      if (i >= 22 && i <= 42) vecs[i].colorsSel = 2'd1;
      if (i >= 43 && i <= 57) vecs[i].colorsSel = 2'd2;
      if (i >= 75) vecs[i].colorsSel = 2'd3;
    end
    foreach (incCycles[k]) vecs[incCycles[k]].expInc = 1'b1;
    foreach (seqs[k]) seqs[k] = 32'd0;
    seqD = 32'd0;

    applyStimulus(1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    modelLfsr = SEED;
    checkOutput("reset Colors", bus.Colors, 32'd0);
    checkOutput("reset ColorsValid", 32'(bus.ColorsValid), 32'd0);
    checkOutput("reset Busy", 32'(bus.Busy), 32'd0);
    checkOutput("reset IncCounter", 32'(bus.IncCounter), 32'd0);
    checkOutput("reset lfsr", 32'(dut.lfsrQ), 32'(SEED));

    for (int i = 0; i < NCYC; i++) begin
      applyStimulus(vecs[i].rst, vecs[i].set);
      if (i >= 6 && i <= 21) seqs[1][2*(i-6) +: 2] = modelLfsr[1:0];
      if (i >= 27 && i <= 42) seqs[2][2*(i-27) +: 2] = modelLfsr[1:0];
      if (i >= 59 && i <= 74) seqs[3][2*(i-59) +: 2] = modelLfsr[1:0];
      if (i == 1 || i == 58) checkOutput($sformatf("lfsr c%0d", i), 32'(dut.lfsrQ), 32'(modelLfsr));
      checkOutput($sformatf("Busy c%0d", i), 32'(bus.Busy), 32'(vecs[i].expBusy));
      checkOutput($sformatf("ColorsValid c%0d", i), 32'(bus.ColorsValid), 32'(vecs[i].expValid));
      checkOutput($sformatf("IncCounter c%0d", i), 32'(bus.IncCounter), 32'(vecs[i].expInc));
      checkOutput($sformatf("Colors c%0d", i), bus.Colors, seqs[vecs[i].colorsSel]);
      advance();
    end

    // Fresh request from DONE; measure edge-to-valid latency with a bounded wait.
    applyStimulus(1'b1, 1'b0);
    advance();
    applyStimulus(1'b1, 1'b1);
    advance();
    lat   = 1;
    found = 1'b0;
    while (lat <= 40 && !found) begin
      if (lat <= 16) seqD[2*(lat-1) +: 2] = modelLfsr[1:0];
      if (bus.ColorsValid) begin
        found = 1'b1;
      end else begin
        advance();
        lat++;
      end
    end
    checkOutput("valid seen", 32'(found), 32'd1);
    checkOutput("latency", 32'(lat), 32'd17);
    checkOutput("Colors after refill", bus.Colors, seqD);

    // Strobe restarts a full period after DONE entry, then repeats every TICKS.
    n = 0;
    while (!bus.IncCounter && n < 10) begin
      advance();
      n++;
    end
    checkOutput("first tick after done", 32'(n), 32'(TICKS - 1));
    advance();
    checkOutput("tick width", 32'(bus.IncCounter), 32'd0);
    n = 1;
    while (!bus.IncCounter && n < 10) begin
      advance();
      n++;
    end
    checkOutput("tick period", 32'(n), 32'(TICKS));

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/color_sequence_gen.md
# color_sequence_gen

Upstream stage of the Simon Says datapath on the Basys3. Generates the 16-entry, 2-bit-per-entry pseudo-random color sequence (`Colors`) consumed by the color master, and the periodic display-advance strobe (`IncCounter`) that paces sequence playback. A new sequence is built on every rising edge of the color master's `SetColors` request. The published sequence stays stable while the next one is being built.

## Interface
Parameters:
- `TICK_DIV`, default 50_000_000: clk cycles per `IncCounter` pulse (1 Hz at 100 MHz). Legal range is 2..2^26.
- `LFSR_SEED`, default 16'hACE1: LFSR value loaded at reset. A seed of 0 is replaced by 16'h0001.

Ports:
- `clk`, input, 1: system clock. All logic is on its rising edge.
- `reset`, input, 1: synchronous, active-low reset.
- `SetColors`, input, 1: regeneration request from the color master. Only its rising edge is significant.
- `Colors`, output, 32: sequence. Entry i is `Colors[2i+1:2i]`, i = 0..15, with entry 0 played first.
- `ColorsValid`, output, 1: high while `Colors` holds a completed sequence.
- `Busy`, output, 1: high while a fill is in progress.
- `IncCounter`, output, 1: single-cycle playback strobe.

## Operation
- **LFSR:** 16-bit Galois LFSR with polynomial x^16+x^14+x^13+x^11+1 (mask 16'hB400).
  - Steps every clk cycle while not in reset, independent of FSM state.
  - Never reaches 0.
- **Request edge:** `set_q` is `SetColors` registered each cycle, reset to 0. A request edge is `SetColors & ~set_q`. A request held high through reset therefore counts as an edge on the first post-reset cycle.
- **FSM** has three states: IDLE, FILL, DONE.
  - IDLE to FILL on a request edge. Clear draw index `idx` to 0 and set `ColorsValid` to 0.
  - In FILL, each cycle: `shadow[2*idx+1:2*idx]` takes `lfsr[1:0]` (current value), then `idx` increments. When `idx==15`, go to DONE next.
  - On entering DONE: `Colors` takes `shadow` and `ColorsValid` goes to 1.
  - DONE to FILL on a request edge, with the same actions as IDLE to FILL.
- **Ignored requests:** request edges arriving during FILL are ignored and are not queued.
- **Output stability:** `Colors` changes only on the DONE-entry cycle. During FILL it holds the previous sequence, or 0 after reset.
- **Tick prescaler:** counter `pcnt` of width clog2(TICK_DIV).
  - `IncCounter`=1 for one cycle when `pcnt==TICK_DIV-1`. `pcnt` then wraps to 0.
  - `pcnt` is cleared to 0 on the DONE-entry cycle, so the first tick after a new sequence comes a full period later.
- **Reset** (reset==0, any state, including mid-FILL):
  - state IDLE, `idx` 0, `shadow` 0, `pcnt` 0
  - `lfsr` takes the seed, `set_q` 0
  - outputs: `Colors` 0, `ColorsValid` 0, `Busy` 0, `IncCounter` 0
  - A partial fill is discarded.

## Timing
- Request edge sampled in cycle N:
  - `Busy`=1 and `ColorsValid`=0 from N+1.
  - Draws happen in cycles N+1..N+16.
  - In cycle N+17: `Busy`=0, `ColorsValid`=1, new `Colors` visible.
- Fixed latency: 17 cycles from edge to valid.
- `IncCounter` period is exactly TICK_DIV cycles between consecutive pulses, except across a DONE entry, which restarts the period.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Structure
- **Package `simon_pkg`:**
  - state enum {IDLE, FILL, DONE}
  - `NUM_COLORS`=16 and `COLOR_W`=2
  - `LFSR_MASK`=16'hB400
  - color code constants (RED, GREEN, BLUE, YELLOW = 0..3)
- **Sub-module `lfsr16`:** inputs `clk`, `reset`, and seed parameter; output `q[15:0]`. Instanced once.
- Everything else, including the prescaler, is in the top module.

## Test plan
- **Reset values:** hold reset low 3 cycles with `SetColors`=0. Require `Colors`=0, `ColorsValid`=0, `Busy`=0, `IncCounter`=0, and internal lfsr=16'hACE1.
- **Fill contents and latency:** release reset, raise `SetColors` at cycle 5 and hold it. Require `Busy` in cycles 6..21 and `ColorsValid` at cycle 22. `Colors` must equal a reference model packing lfsr[1:0] from cycles 6..21 in that order.
- **Ignored mid-fill request:** toggle `SetColors` 0→1 at cycle 10 during the fill. Require exactly one `ColorsValid` rise (cycle 22) and no second fill.
- **Stable output during regeneration:** from DONE, issue a new edge. Require `Colors` to hold the old value for 16 cycles, then change on the valid cycle.
- **Prescaler:** set TICK_DIV=4 and run free. Require `IncCounter` pulses exactly every 4 cycles, each one cycle wide. On DONE entry, the next pulse comes 4 cycles later.
- **Reset mid-fill:** assert reset at the 8th FILL cycle for 1 cycle. Require all outputs 0 the next cycle. With `SetColors` still high, a fresh fill must start and complete 17 cycles later.
